// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the PWM timer and its profile sequencer:
//   - timer register addresses (also decoded by the timer itself)
//   - profile-table field codes
//   - sequencer state enumeration
//   - length of the timer end pulse
// ---------------------------------------------------------------------------
package timer_pkg;

  // Timer register map
  localparam logic [1:0] TMR_ADDR_MAX  = 2'd0;
  localparam logic [1:0] TMR_ADDR_PWM  = 2'd1;
  localparam logic [1:0] TMR_ADDR_STOP = 2'd2;

  // Profile-table fields; they deliberately share the timer address codes so a
  // table field can be forwarded straight onto the timer address bus.
  localparam logic [1:0] FLD_MAX  = TMR_ADDR_MAX;
  localparam logic [1:0] FLD_PWM  = TMR_ADDR_PWM;
  localparam logic [1:0] FLD_STOP = TMR_ADDR_STOP;
  localparam logic [1:0] FLD_RSVD = 2'd3;

  // Cycles the timer holds its end pulse high per run
  localparam int TMR_END_CYCLES = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_MAX,
    S_WR_PWM,
    S_WR_STOP,
    S_START,
    S_WAIT_HI,
    S_WAIT_LO,
    S_SETTLE
  } seq_state_e;

  // Table field (and timer address) written by a given write state.
  function automatic logic [1:0] state_field(seq_state_e s);
    case (s)
      S_WR_PWM:  return FLD_PWM;
      S_WR_STOP: return FLD_STOP;
      default:   return FLD_MAX;
    endcase
  endfunction

  function automatic logic is_write_state(seq_state_e s);
    return (s == S_WR_MAX) || (s == S_WR_PWM) || (s == S_WR_STOP);
  endfunction

endpackage

// File: rtl/timer_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// timer_seq_ctrl_if
// Register-write / start / end link between the profile sequencer and the
// PWM timer.
//   o_t_we      sequencer -> timer  register write enable
//   o_t_addr    sequencer -> timer  register address (max/pwm/stop)
//   o_t_wdata   sequencer -> timer  register data
//   o_t_start   sequencer -> timer  one-cycle start pulse
//   i_timer_end timer -> sequencer  end-of-run pulse
// master = sequencer side, slave = timer side.
// ---------------------------------------------------------------------------
interface timer_seq_ctrl_if;
  logic        o_t_we;
  logic [1:0]  o_t_addr;
  logic [15:0] o_t_wdata;
  logic        o_t_start;
  logic        i_timer_end;

  modport master (
    output o_t_we,
    output o_t_addr,
    output o_t_wdata,
    output o_t_start,
    input  i_timer_end
  );

  modport slave (
    input  o_t_we,
    input  o_t_addr,
    input  o_t_wdata,
    input  o_t_start,
    output i_timer_end
  );
endinterface

// File: rtl/timer_seq_table.sv
// ---------------------------------------------------------------------------
// timer_seq_table
// Profile register file: P_ENTRIES entries x 3 fields x 16 bits.
//   i_clk, i_rst_n  clock, asynchronous active-low reset (clears the table)
//   i_we            write strobe (already qualified by the caller)
//   i_waddr         {entry, field}; field 3 is ignored
//   i_wdata         write data
//   i_ridx          read entry
//   i_rfield        read field; field 3 reads as zero
//   o_rdata         asynchronous read data
// ---------------------------------------------------------------------------
module timer_seq_table
  import timer_pkg::*;
#(
  parameter int P_ENTRIES = 4,
  parameter int P_IDXW    = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [P_IDXW+1:0] i_waddr,
  input  logic [15:0]       i_wdata,
  input  logic [P_IDXW-1:0] i_ridx,
  input  logic [1:0]        i_rfield,
  output logic [15:0]       o_rdata
);

  logic [15:0] mem_q [P_ENTRIES][3];

  logic [P_IDXW-1:0] w_entry;
  logic [1:0]        w_field;

  assign w_entry = i_waddr[P_IDXW+1:2];
  assign w_field = i_waddr[1:0];

  // NOTE: the table is a small flop array that must power up as all zeros, so
  // it sits on the async reset like any other register instead of being left
  // as an unreset RAM.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int e = 0; e < P_ENTRIES; e++) begin
        for (int f = 0; f < 3; f++) begin
          mem_q[e][f] <= '0;
        end
      end
    end else if (i_we) begin
      case (w_field)
        FLD_MAX:  mem_q[w_entry][0] <= i_wdata;
        FLD_PWM:  mem_q[w_entry][1] <= i_wdata;
        FLD_STOP: mem_q[w_entry][2] <= i_wdata;
        default:  ;  // reserved field: write dropped
      endcase
    end
  end

  always_comb begin
    o_rdata = '0;
    case (i_rfield)
      FLD_MAX:  o_rdata = mem_q[i_ridx][0];
      FLD_PWM:  o_rdata = mem_q[i_ridx][1];
      FLD_STOP: o_rdata = mem_q[i_ridx][2];
      default:  o_rdata = '0;
    endcase
  end

endmodule

// File: rtl/timer_seq_ctrl.sv
// ---------------------------------------------------------------------------
// timer_seq_ctrl
// Plays a programmed list of timer profiles (max, pwm, stop) into the PWM
// timer: writes the three timer registers, pulses start, waits for the end
// pulse plus a settle gap, then advances. Single-pass or looping playback.
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_cfg_we/addr/wdata  profile-table write port ({entry, field}), IDLE only
//   i_last_idx      final entry to play (sampled at go)
//   i_loop          wrap to entry 0 after the final entry (sampled at go)
//   i_go            start playback (level, IDLE only)
//   i_stop          halt at the next entry boundary (sticky while busy)
//   tmr             timer link (register writes, start, end pulse)
//   o_busy          high in every state except IDLE
//   o_idx           entry currently being played
//   o_done          one-cycle pulse when playback ends
// All outputs are registered; output flops load the value implied by the
// next state, so they line up with the state they describe.
// ---------------------------------------------------------------------------
module timer_seq_ctrl
  import timer_pkg::*;
#(
  parameter int P_ENTRIES = 4,
  parameter int P_IDXW    = 2,
  parameter int P_SETTLE  = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cfg_we,
  input  logic [P_IDXW+1:0] i_cfg_addr,
  input  logic [15:0]       i_cfg_wdata,
  input  logic [P_IDXW-1:0] i_last_idx,
  input  logic              i_loop,
  input  logic              i_go,
  input  logic              i_stop,
  timer_seq_ctrl_if.master  tmr,
  output logic              o_busy,
  output logic [P_IDXW-1:0] o_idx,
  output logic              o_done
);

  localparam int CNT_W = (P_SETTLE > 1) ? $clog2(P_SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P_SETTLE - 1);

  seq_state_e        state_q, state_d;
  logic [P_IDXW-1:0] idx_q, idx_d;
  logic [P_IDXW-1:0] last_q, last_d;
  logic              loop_q, loop_d;
  logic              stop_q, stop_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              finish;

  logic              t_we_q, t_we_d;
  logic [1:0]        t_addr_q, t_addr_d;
  logic [15:0]       t_wdata_q, t_wdata_d;
  logic              t_start_q, t_start_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [1:0]        rd_field;
  logic [15:0]       rd_data;
  logic              stop_pend;

  // -------------------------------------------------------------------------
  // Profile table; writes are locked out while a playback is running.
  // -------------------------------------------------------------------------
  assign rd_field = state_field(state_d);

  timer_seq_table #(
    .P_ENTRIES (P_ENTRIES),
    .P_IDXW    (P_IDXW)
  ) u_table (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_we     (i_cfg_we && (state_q == S_IDLE)),
    .i_waddr  (i_cfg_addr),
    .i_wdata  (i_cfg_wdata),
    .i_ridx   (idx_d),
    .i_rfield (rd_field),
    .o_rdata  (rd_data)
  );

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  // NOTE: every flop here is written with <= so all registers update from the
  // same pre-edge values; blocking writes would make the result depend on
  // statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      last_q    <= '0;
      loop_q    <= 1'b0;
      stop_q    <= 1'b0;
      cnt_q     <= '0;
      t_we_q    <= 1'b0;
      t_addr_q  <= '0;
      t_wdata_q <= '0;
      t_start_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      loop_q    <= loop_d;
      stop_q    <= stop_d;
      cnt_q     <= cnt_d;
      t_we_q    <= t_we_d;
      t_addr_q  <= t_addr_d;
      t_wdata_q <= t_wdata_d;
      t_start_q <= t_start_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // A stop raised in the very cycle SETTLE ends still counts.
  assign stop_pend = stop_q || i_stop;

  // NOTE: each variable gets its hold value before the case statement, so
  // paths that do not assign it cannot infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    loop_d  = loop_q;
    cnt_d   = cnt_q;
    finish  = 1'b0;
    // The stop request only latches while busy; IDLE handles go+stop itself.
    stop_d  = stop_q || (i_stop && (state_q != S_IDLE));

    unique case (state_q)
      S_IDLE: begin
        if (i_go) begin
          if (i_stop) begin
            stop_d = 1'b0;
          end else begin
            last_d  = i_last_idx;
            loop_d  = i_loop;
            idx_d   = '0;
            state_d = S_WR_MAX;
          end
        end
      end
      S_WR_MAX:  state_d = S_WR_PWM;
      S_WR_PWM:  state_d = S_WR_STOP;
      S_WR_STOP: state_d = S_START;
      S_START:   state_d = S_WAIT_HI;
      S_WAIT_HI: begin
        if (tmr.i_timer_end) state_d = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (!tmr.i_timer_end) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end
      end
      S_SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          if (stop_pend || ((idx_q == last_q) && !loop_q)) begin
            state_d = S_IDLE;
            stop_d  = 1'b0;
            finish  = 1'b1;
          end else begin
            idx_d   = (idx_q == last_q) ? '0 : idx_q + P_IDXW'(1);
            state_d = S_WR_MAX;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic, evaluated on the next state so the registered outputs are
  // valid in the same cycle as the state they belong to.
  // -------------------------------------------------------------------------
  always_comb begin
    t_we_d    = is_write_state(state_d);
    t_addr_d  = t_we_d ? rd_field : 2'd0;
    t_wdata_d = t_we_d ? rd_data : 16'd0;
    t_start_d = (state_d == S_START);
    busy_d    = (state_d != S_IDLE);
    done_d    = finish;
  end

  assign tmr.o_t_we    = t_we_q;
  assign tmr.o_t_addr  = t_addr_q;
  assign tmr.o_t_wdata = t_wdata_q;
  assign tmr.o_t_start = t_start_q;
  assign o_busy        = busy_q;
  assign o_idx         = idx_q;
  assign o_done        = done_q;

endmodule

// File: tb/tb_timer_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_timer_seq_ctrl
// Directed bench for the timer profile sequencer with a small behavioural
// timer that answers each start with a delayed 10-cycle end pulse.
// ---------------------------------------------------------------------------
module tb_timer_seq_ctrl;
  import timer_pkg::*;

  localparam int P_ENTRIES = 4;
  localparam int P_IDXW    = 2;
  localparam int P_SETTLE  = 2;
  localparam int TM_DLY    = 2;  // timer cycles from start to end rising

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_we = 1'b0;
  logic [P_IDXW+1:0] cfg_addr = '0;
  logic [15:0]       cfg_wdata = '0;
  logic [P_IDXW-1:0] last_idx = '0;
  logic              loop_en = 1'b0;
  logic              go = 1'b0;
  logic              stop = 1'b0;
  logic              busy;
  logic [P_IDXW-1:0] idx_o;
  logic              done;

  timer_seq_ctrl_if tmr ();

  timer_seq_ctrl #(
    .P_ENTRIES (P_ENTRIES),
    .P_IDXW    (P_IDXW),
    .P_SETTLE  (P_SETTLE)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_cfg_we    (cfg_we),
    .i_cfg_addr  (cfg_addr),
    .i_cfg_wdata (cfg_wdata),
    .i_last_idx  (last_idx),
    .i_loop      (loop_en),
    .i_go        (go),
    .i_stop      (stop),
    .tmr         (tmr),
    .o_busy      (busy),
    .o_idx       (idx_o),
    .o_done      (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Cycle counter
  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Behavioural timer: end high for TMR_END_CYCLES after TM_DLY cycles.
  int tm_cnt = 0;
  initial begin
    tmr.i_timer_end = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        tm_cnt = 0;
        tmr.i_timer_end = 1'b0;
      end else if (tm_cnt == 0) begin
        if (tmr.o_t_start) tm_cnt = 1;
      end else begin
        tm_cnt++;
        tmr.i_timer_end = (tm_cnt > TM_DLY) && (tm_cnt <= TM_DLY + TMR_END_CYCLES);
        if (tm_cnt > TM_DLY + TMR_END_CYCLES) tm_cnt = 0;
      end
    end
  end

  // Monitor: logs timer writes, counts starts/dones, notes end falling edges.
  typedef struct packed {
    logic [P_IDXW-1:0] idx;
    logic [1:0]        addr;
    logic [15:0]       data;
  } wr_t;

  wr_t  wr_log[$];
  int   n_starts = 0;
  int   n_dones  = 0;
  int   fall_cyc = 0;
  int   done_cyc = 0;
  logic end_prev = 1'b0;

  initial forever begin
    wr_t w;
    @(posedge clk);
    #2;
    if (tmr.o_t_we) begin
      w.idx  = idx_o;
      w.addr = tmr.o_t_addr;
      w.data = tmr.o_t_wdata;
      wr_log.push_back(w);
    end
    if (tmr.o_t_start) n_starts++;
    if (done) begin
      n_dones++;
      done_cyc = cyc;
    end
    if (end_prev && !tmr.i_timer_end) fall_cyc = cyc;
    end_prev = tmr.i_timer_end;
  end

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic cfg_write(input int e, input int f, input int d);
    cfg_addr  = (P_IDXW+2)'(e * 4 + f);
    cfg_wdata = 16'(d);
    cfg_we    = 1'b1;
    step();
    cfg_we    = 1'b0;
  endtask

  task automatic start_play(input int last, input bit lp);
    last_idx = P_IDXW'(last);
    loop_en  = lp;
    go       = 1'b1;
    step();
    go       = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (done) seen = 1'b1;
    end
  endtask

  task automatic wait_starts(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (n_starts >= target) ok = 1'b1;
      else step();
    end
  endtask

  int exp_tab [3][3] = '{'{10, 4, 2}, '{20, 5, 3}, '{30, 6, 0}};
  int exp_grp [3]    = '{0, 1, 0};

  initial begin
    bit ok;
    int bw, bs, bd;

    // ---------------- reset state ----------------
    step();
    step();
    check("rst_we",    tmr.o_t_we, 0);
    check("rst_addr",  tmr.o_t_addr, 0);
    check("rst_wdata", tmr.o_t_wdata, 0);
    check("rst_start", tmr.o_t_start, 0);
    check("rst_busy",  busy, 0);
    check("rst_idx",   idx_o, 0);
    check("rst_done",  done, 0);
    rst_n = 1'b1;
    step();

    // ---------------- program table ----------------
    for (int e = 0; e < 3; e++)
      for (int f = 0; f < 3; f++)
        cfg_write(e, f, exp_tab[e][f]);
    cfg_write(0, 3, 777);  // reserved field: dropped

    // ---------------- single pass, entry 0 ----------------
    bs = n_starts; bd = n_dones;
    start_play(0, 1'b0);            // now in cycle 1
    check("t1_c1_we",   tmr.o_t_we, 1);
    check("t1_c1_addr", tmr.o_t_addr, 0);
    check("t1_c1_data", tmr.o_t_wdata, 10);
    check("t1_c1_busy", busy, 1);
    check("t1_c1_idx",  idx_o, 0);
    step();
    check("t1_c2_addr", tmr.o_t_addr, 1);
    check("t1_c2_data", tmr.o_t_wdata, 4);
    step();
    check("t1_c3_addr", tmr.o_t_addr, 2);
    check("t1_c3_data", tmr.o_t_wdata, 2);
    step();
    check("t1_c4_start", tmr.o_t_start, 1);
    check("t1_c4_we",    tmr.o_t_we, 0);
    wait_done(100, ok);
    check("t1_done_seen", ok, 1);
    check("t1_done_gap", done_cyc - fall_cyc, 1 + P_SETTLE);
    check("t1_busy_at_done", busy, 0);
    step();
    check("t1_done_pulse", done, 0);
    check("t1_starts", n_starts - bs, 1);
    check("t1_dones",  n_dones - bd, 1);

    // ---------------- three entries, single pass ----------------
    bw = wr_log.size(); bs = n_starts; bd = n_dones;
    start_play(2, 1'b0);
    wait_done(200, ok);
    check("t2_done_seen", ok, 1);
    step();
    check("t2_starts", n_starts - bs, 3);
    check("t2_dones",  n_dones - bd, 1);
    check("t2_writes", wr_log.size() - bw, 9);
    if (wr_log.size() - bw == 9) begin
      for (int j = 0; j < 9; j++) begin
        check("t2_wr_idx",  wr_log[bw+j].idx, j / 3);
        check("t2_wr_addr", wr_log[bw+j].addr, j % 3);
        check("t2_wr_data", wr_log[bw+j].data, exp_tab[j/3][j%3]);
      end
    end

    // ---------------- loop, stop in third run, config write while busy ----
    bw = wr_log.size(); bs = n_starts; bd = n_dones;
    start_play(1, 1'b1);
    wait_starts(bs + 1, 50, ok);
    check("t3_first_start", ok, 1);
    cfg_write(0, 0, 99);             // busy: must be dropped
    wait_starts(bs + 3, 200, ok);
    check("t3_third_start", ok, 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    wait_done(100, ok);
    check("t3_done_seen", ok, 1);
    for (int i = 0; i < 40; i++) step();
    check("t3_starts", n_starts - bs, 3);
    check("t3_dones",  n_dones - bd, 1);
    check("t3_writes", wr_log.size() - bw, 9);
    check("t3_busy_after", busy, 0);
    if (wr_log.size() - bw == 9) begin
      for (int g = 0; g < 3; g++)
        check("t3_grp_idx", wr_log[bw+3*g].idx, exp_grp[g]);
      check("t3_max_kept", wr_log[bw+6].data, 10);
    end

    // ---------------- go and stop together ----------------
    bw = wr_log.size(); bs = n_starts; bd = n_dones;
    stop = 1'b1;
    start_play(0, 1'b0);
    stop = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t4_busy_low", busy, 0);
    end
    check("t4_no_writes", wr_log.size() - bw, 0);
    start_play(1, 1'b0);
    wait_done(200, ok);
    check("t4_done_seen", ok, 1);
    check("t4_starts", n_starts - bs, 2);
    check("t4_writes", wr_log.size() - bw, 6);
    if (wr_log.size() - bw > 0) check("t4_first_data", wr_log[bw].data, 10);

    // ---------------- reset during WAIT_HI ----------------
    bs = n_starts;
    start_play(1, 1'b1);
    wait_starts(bs + 2, 200, ok);
    check("t5_second_start", ok, 1);
    step();                          // WAIT_HI of entry 1
    check("t5_pre_idx",  idx_o, 1);
    check("t5_pre_busy", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    check("t5_rst_we",    tmr.o_t_we, 0);
    check("t5_rst_addr",  tmr.o_t_addr, 0);
    check("t5_rst_wdata", tmr.o_t_wdata, 0);
    check("t5_rst_start", tmr.o_t_start, 0);
    check("t5_rst_busy",  busy, 0);
    check("t5_rst_idx",   idx_o, 0);
    check("t5_rst_done",  done, 0);
    for (int i = 0; i < 3; i++) step();
    rst_n = 1'b1;
    step();
    check("t5_idle_busy", busy, 0);
    start_play(0, 1'b0);
    check("t5_clr_max",  tmr.o_t_wdata, 0);
    step();
    check("t5_clr_pwm",  tmr.o_t_wdata, 0);
    step();
    check("t5_clr_stop", tmr.o_t_wdata, 0);
    wait_done(100, ok);
    check("t5_done_seen", ok, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
